if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage of the ARM pipeline. It sits in front of the combinational instruction memory. It owns the program counter, drives the memory address, and captures each returned word together with its PC+4 into a small in-order queue. Decode drains the queue with a valid/ready handshake. Branch redirects from execute and global hazard freezes steer the PC; a redirect flushes all queued, not-yet-consumed instructions.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word aligned.
- `QUEUE_DEPTH`, default 2: fetch-queue entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_addr`  out  32  byte address to instruction memory; equals `fetch_pc` combinationally.
- `imem_inst`  in  32  instruction word for `imem_addr`; valid in the same cycle (zero-latency memory).
- `freeze`  in  1  hazard stall; blocks fetching only.
- `branch_taken`  in  1  redirect request from execute.
- `branch_addr`  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- `id_valid`  out  1  queue head holds a valid instruction.
- `id_ready`  in  1  decode accepts the head this cycle.
- `id_inst`  out  32  head instruction; 0 when `id_valid`=0.
- `id_pc`  out  32  head PC+4; 0 when `id_valid`=0.

## Operation
- Registered state: `fetch_pc` (32 bits), queue storage, read/write pointers, and `count` (0..QUEUE_DEPTH).
- Occupancy states: EMPTY (`count`=0), PARTIAL, FULL (`count`=QUEUE_DEPTH).
- pop = `id_valid` & `id_ready`.
- push = !`branch_taken` & !`freeze` & (`count`<QUEUE_DEPTH | pop).
  - Push writes {`fetch_pc`+4, `imem_inst`} at the write pointer.
  - `fetch_pc` <= `fetch_pc`+4.
- Push and pop in the same cycle leave `count` unchanged. This is legal when FULL: a pop from FULL frees the slot for the same-cycle push.
- `branch_taken`=1 has priority over everything:
  - `fetch_pc` <= {`branch_addr`[31:2], 2'b00}.
  - `count`, read pointer and write pointer all reset to 0.
  - No push this cycle.
  - A same-cycle pop still counts as consumed by decode, but the queue is emptied regardless.
- `freeze`=1 with no branch: `fetch_pc` holds and no push occurs. Pops continue normally, so decode can drain the queue.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0, and `id_pc` wraps the same way.
- Pointers wrap modulo QUEUE_DEPTH.
- Output ordering is strict program order between redirects. There are no duplicates and no drops.

## Timing
- Reset (asynchronous): `fetch_pc`=RESET_PC, `count`=0, so `imem_addr`=RESET_PC, `id_valid`=0, `id_inst`=0, `id_pc`=0.
- First push happens on the first rising edge after `rst` deasserts. `id_valid`=1 from that edge onward.
- Latency: an instruction appears at `id_*` one cycle after its address is driven on `imem_addr`. Steady-state throughput is one instruction per cycle.
- Redirect: on the edge where `branch_taken`=1, `imem_addr` becomes the target and `id_valid`=0. The target instruction is at `id_*` one edge later. Branch penalty in fetch is one bubble.
- When `rst` is asserted mid-operation, all queue contents are discarded immediately and state returns to reset values without waiting for a clock edge.
- `id_inst` and `id_pc` are driven from queue storage through a read mux, with no combinational path from `imem_inst`. `imem_addr` has no combinational dependency on any input.

## Structure
- Package `if_pkg`:
  - `if_entry_t` struct {`pc4`[31:0], `inst`[31:0]}.
  - Constant `INST_BYTES`=4.
  - Helper function `align_word`.
- Sub-module `fetch_queue`: parameterized synchronous FIFO of `if_entry_t` with push, pop, flush, full, empty and count.
- `if_fetch_unit` contains the PC register, push/pop/redirect control, and one `fetch_queue` instance.

## Test plan
The bench memory model returns `imem_inst` = 32'hE000_0000 | `imem_addr`.
- Reset, then `id_ready`=1 continuously for 4 cycles → `id_inst` = E000_0000, E000_0004, E000_0008, E000_000C on consecutive cycles, with `id_pc` = 4, 8, C, 10.
- Hold `id_ready`=0 for 5 cycles after reset:
  - Queue fills to 2 and `fetch_pc` stalls at 8.
  - `imem_addr` holds at 8.
  - On release, the output sequence is E000_0000, E000_0004, E000_0008 with no gap.
- `branch_taken`=1 with `branch_addr`=32'h0000_0103 while the queue is FULL:
  - Next cycle `id_valid`=0 and `imem_addr`=0x100.
  - The cycle after, `id_inst`=E000_0100 and `id_pc`=0x104.
- `freeze`=1 for 3 cycles with `id_ready`=1: queue drains to EMPTY, `imem_addr` stays constant, then fetching resumes from that address.
- `branch_taken` and `freeze` together with target 0x40 → branch wins: `imem_addr`=0x40, queue flushed.
- Redirect to 0xFFFF_FFFC, then run 2 cycles: instruction at 0xFFFF_FFFC delivered with `id_pc`=0, followed by instruction at 0x0 with `id_pc`=4. Separately, assert `rst` mid-stream → `id_valid`=0 and `imem_addr`=RESET_PC immediately, before the next edge.

Source files
------------

// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_pkg
//  Description : Shared types and helpers for the instruction-fetch stage.
//  Revision    : 1.0  initial release
// ============================================================================
package if_pkg;

    // Byte distance between consecutive instruction words
    localparam logic [31:0] INST_BYTES = 32'd4;

    // One fetch-queue entry: the fetched word and the PC of the next word
    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] inst;
    } if_entry_t;

    // Clear the byte-offset bits so the address points at a whole word
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : In-order FIFO of fetched instructions with single-cycle
//                flush. Push and pop may occur together, even when full.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  if_entry_t                i_wdata,
    output if_entry_t                o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] c_PTR_ONE  = PW'(1);
    localparam logic [PW:0]   c_CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   c_CNT_FULL = (PW+1)'(DEPTH);

    if_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    // Flush wins over both operations; a pop on an empty queue is ignored
    assign w_do_push = i_push & ~i_flush;
    assign w_do_pop  = i_pop & ~i_flush & (r_count != '0);

    // Entry storage needs no reset: the count decides what is valid
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power of two)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == c_CNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit
//  Description : Instruction-fetch stage. Owns the PC, drives the zero-latency
//                instruction memory and queues {PC+4, inst} for decode.
//                Branch redirects flush the queue; freeze stalls fetching.
//  Revision    : 1.0  initial release
// ============================================================================
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
)
(
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic [31:0]   r_fetch_pc;
    logic          w_pop;
    logic          w_push;
    logic          w_full;
    logic          w_empty;
    logic          w_head_live;
    logic [CW-1:0] w_count;
    if_entry_t     w_new;
    if_entry_t     w_head;

    // Decode consumes the head; a full queue may accept a push in the same
    // cycle because the pop frees the slot being written.
    assign w_pop  = id_valid & id_ready;
    assign w_push = ~branch_taken & ~freeze & (~w_full | w_pop);

    assign w_new = '{pc4: r_fetch_pc + INST_BYTES, inst: imem_inst};

    // Program counter: redirect first, then advance on every accepted fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (branch_taken) begin
            r_fetch_pc <= align_word(branch_addr);
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + INST_BYTES;
        end
    end

    fetch_queue #(
        .DEPTH   (QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (branch_taken),
        .i_wdata (w_new),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Memory address comes straight from the PC register only
    assign imem_addr = r_fetch_pc;

    // Head data is zeroed whenever no entry is held
    assign id_valid    = ~w_empty;
    assign w_head_live = (w_count != '0);
    assign id_inst     = w_head_live ? w_head.inst : 32'h0;
    assign id_pc       = w_head_live ? w_head.pc4  : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_unit
//  Description : Self-checking bench for if_fetch_unit with a queue-based
//                reference model of the fetch stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QD       = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        id_ready;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: queued fetch addresses in program order, plus next PC
    logic [31:0] m_q[$];
    logic [31:0] m_pc;

    assign imem_inst = 32'hE000_0000 | imem_addr;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .RESET_PC     (RESET_PC),
        .QUEUE_DEPTH  (QD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_inst    (imem_inst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_inst      (id_inst),
        .id_pc        (id_pc)
    );

    task automatic model_reset();
        m_q.delete();
        m_pc = RESET_PC;
    endtask

    // Apply one rising edge's worth of fetch-stage rules to the model
    task automatic model_edge();
        logic pop;
        pop = (m_q.size() > 0) && id_ready;
        if (branch_taken) begin
            m_q.delete();
            m_pc = branch_addr & 32'hFFFF_FFFC;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (!freeze && m_q.size() < QD) begin
                m_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // Inputs are changed at the falling edge; outputs are read there too
    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'h0;
        id_ready     = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #1;
        n_checks++; if (id_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", id_valid); else n_pass++;
        n_checks++; if (id_inst !== 32'h0) $display("FAIL reset_inst: got %h want 0", id_inst); else n_pass++;
        n_checks++; if (id_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", id_pc); else n_pass++;
        n_checks++; if (imem_addr !== RESET_PC) $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); else n_pass++;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stream();
        apply_reset();
        id_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            n_checks++; if (id_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b want 1", k, id_valid); else n_pass++;
            n_checks++; if (id_inst !== (32'hE000_0000 | (32'(k) * 4))) $display("FAIL stream_inst[%0d]: got %h want %h", k, id_inst, 32'hE000_0000 | (32'(k) * 4)); else n_pass++;
            n_checks++; if (id_pc !== (32'(k) * 4 + 4)) $display("FAIL stream_pc[%0d]: got %h want %h", k, id_pc, 32'(k) * 4 + 4); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int k = 0; k < 5; k++) cycle();
        n_checks++; if (imem_addr !== 32'h8) $display("FAIL bp_addr: got %h want 8", imem_addr); else n_pass++;
        n_checks++; if (id_inst !== 32'hE000_0000) $display("FAIL bp_head: got %h want e0000000", id_inst); else n_pass++;
        id_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            cycle();
            n_checks++; if (id_inst !== (32'hE000_0000 | (32'(k) * 4)) || id_valid !== 1'b1) $display("FAIL bp_release[%0d]: got v=%b %h want v=1 %h", k, id_valid, id_inst, 32'hE000_0000 | (32'(k) * 4)); else n_pass++;
        end
    endtask

    task automatic test_branch_full();
        apply_reset();
        for (int k = 0; k < 3; k++) cycle();
        n_checks++; if (imem_addr !== 32'h8) $display("FAIL brf_prefill: got %h want 8", imem_addr); else n_pass++;
        branch_taken = 1'b1;
        branch_addr  = 32'h0000_0103;
        cycle();
        branch_taken = 1'b0;
        n_checks++; if (id_valid !== 1'b0) $display("FAIL brf_bubble: got %b want 0", id_valid); else n_pass++;
        n_checks++; if (imem_addr !== 32'h100) $display("FAIL brf_target: got %h want 100", imem_addr); else n_pass++;
        id_ready = 1'b1;
        cycle();
        n_checks++; if (id_inst !== 32'hE000_0100) $display("FAIL brf_inst: got %h want e0000100", id_inst); else n_pass++;
        n_checks++; if (id_pc !== 32'h104) $display("FAIL brf_pc: got %h want 104", id_pc); else n_pass++;
    endtask

    task automatic test_freeze();
        apply_reset();
        for (int k = 0; k < 3; k++) cycle();
        freeze   = 1'b1;
        id_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++; if (imem_addr !== 32'h8) $display("FAIL frz_addr[%0d]: got %h want 8", k, imem_addr); else n_pass++;
        end
        n_checks++; if (id_valid !== 1'b0) $display("FAIL frz_drained: got %b want 0", id_valid); else n_pass++;
        freeze = 1'b0;
        cycle();
        n_checks++; if (id_inst !== 32'hE000_0008 || id_pc !== 32'hC) $display("FAIL frz_resume: got %h/%h want e0000008/c", id_inst, id_pc); else n_pass++;
    endtask

    task automatic test_branch_freeze();
        apply_reset();
        for (int k = 0; k < 3; k++) cycle();
        freeze       = 1'b1;
        branch_taken = 1'b1;
        branch_addr  = 32'h0000_0040;
        cycle();
        freeze       = 1'b0;
        branch_taken = 1'b0;
        n_checks++; if (imem_addr !== 32'h40) $display("FAIL bfz_addr: got %h want 40", imem_addr); else n_pass++;
        n_checks++; if (id_valid !== 1'b0) $display("FAIL bfz_flush: got %b want 0", id_valid); else n_pass++;
        cycle();
        n_checks++; if (id_inst !== 32'hE000_0040) $display("FAIL bfz_inst: got %h want e0000040", id_inst); else n_pass++;
    endtask

    task automatic test_wrap();
        apply_reset();
        id_ready     = 1'b1;
        cycle();
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFF_FFFC;
        cycle();
        branch_taken = 1'b0;
        cycle();
        n_checks++; if (id_inst !== 32'hFFFF_FFFC || id_pc !== 32'h0) $display("FAIL wrap_last: got %h/%h want fffffffc/0", id_inst, id_pc); else n_pass++;
        cycle();
        n_checks++; if (id_inst !== 32'hE000_0000 || id_pc !== 32'h4) $display("FAIL wrap_first: got %h/%h want e0000000/4", id_inst, id_pc); else n_pass++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        id_ready = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (id_valid !== 1'b0) $display("FAIL arst_valid: got %b want 0", id_valid); else n_pass++;
        n_checks++; if (imem_addr !== RESET_PC) $display("FAIL arst_addr: got %h want %h", imem_addr, RESET_PC); else n_pass++;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        apply_reset();
        for (int k = 0; k < 400; k++) begin
            id_ready     = ($urandom_range(0, 2) != 0);
            freeze       = ($urandom_range(0, 4) == 0);
            branch_taken = ($urandom_range(0, 9) == 0);
            branch_addr  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                        : $urandom;
            cycle();
            ev = (m_q.size() > 0);
            ei = ev ? (32'hE000_0000 | m_q[0]) : 32'h0;
            ep = ev ? (m_q[0] + 32'd4) : 32'h0;
            n_checks++; if (id_valid !== ev) $display("FAIL rnd_valid[%0d]: got %b want %b", k, id_valid, ev); else n_pass++;
            n_checks++; if (id_inst !== ei) $display("FAIL rnd_inst[%0d]: got %h want %h", k, id_inst, ei); else n_pass++;
            n_checks++; if (id_pc !== ep) $display("FAIL rnd_pc[%0d]: got %h want %h", k, id_pc, ep); else n_pass++;
            n_checks++; if (imem_addr !== m_pc) $display("FAIL rnd_addr[%0d]: got %h want %h", k, imem_addr, m_pc); else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_stream();
        test_backpressure();
        test_branch_full();
        test_freeze();
        test_branch_freeze();
        test_wrap();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
